// File: rtl/conv_pkg.sv
// Shared geometry, widths and FSM state type for the 14x14 / 3x3 convolution frame controller.
package conv_pkg;
   localparam int DEF_IMG_W   = 14;
   localparam int DEF_IMG_H   = 14;
   localparam int DEF_K       = 3;
   localparam int DEF_MAC_LAT = 2;

   localparam int OFM_W = DEF_IMG_W - DEF_K + 1;
   localparam int OFM_H = DEF_IMG_H - DEF_K + 1;
   localparam int N_PIX = DEF_IMG_W * DEF_IMG_H;
   localparam int N_WGT = DEF_K * DEF_K;

   localparam int RC_W  = $clog2(DEF_IMG_W);
   localparam int IDX_W = $clog2(OFM_W * OFM_H);
   localparam int PIX_W = $clog2(N_PIX);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      CONV  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/conv_valid_delay.sv
// LAT-deep valid + OFM index delay line modelling the MAC pipeline; reset empties it.
module conv_valid_delay #(
   parameter int LAT = 2,
   parameter int IW  = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_vld,
   input  logic [IW-1:0] i_idx,
   output logic          o_vld,
   output logic [IW-1:0] o_idx
);
   logic [LAT:1]         r_vld_pipe;
   logic [LAT:1][IW-1:0] r_idx_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_idx_pipe <= '0;
      end else begin
         for (int i = LAT; i > 1; i--) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_idx_pipe[i] <= r_idx_pipe[i-1];
         end
         r_vld_pipe[1] <= i_vld;
         r_idx_pipe[1] <= i_idx;
      end
   end

   assign o_vld = r_vld_pipe[LAT];
   assign o_idx = r_idx_pipe[LAT];
endmodule

// File: rtl/conv_frame_sched.sv
// Frame controller: counts IFM pixels, strobes weight/line-buffer writes, issues 3x3 windows
// and reports MAC results through a fixed-latency delay line.
module conv_frame_sched import conv_pkg::*; #(
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int K       = DEF_K,
   parameter int MAC_LAT = DEF_MAC_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             busy,
   output logic [RC_W-1:0]  pix_row,
   output logic [RC_W-1:0]  pix_col,
   output logic             wgt_we,
   output logic [3:0]       wgt_addr,
   output logic             lb_we,
   output logic             win_valid,
   output logic [RC_W-1:0]  win_row,
   output logic [RC_W-1:0]  win_col,
   output logic             out_valid,
   output logic [IDX_W-1:0] ofm_idx,
   output logic             frame_done,
   output logic             proto_err
);
   localparam int OW   = IMG_W - K + 1;
   localparam int NOFM = OW * (IMG_H - K + 1);
   localparam logic [RC_W-1:0]  KM1      = RC_W'(K - 1);
   localparam logic [RC_W-1:0]  LAST_R   = RC_W'(IMG_H - 1);
   localparam logic [RC_W-1:0]  LAST_C   = RC_W'(IMG_W - 1);
   localparam logic [PIX_W-1:0] NWGT     = PIX_W'(K * K);
   localparam logic [IDX_W-1:0] LAST_OFM = IDX_W'(NOFM - 1);

   state_t            r_state, w_nxt;
   logic [RC_W-1:0]   r_row, r_col;
   logic [PIX_W-1:0]  r_pix;
   logic              r_win_valid, r_busy, r_frame_done, r_proto_err;
   logic [RC_W-1:0]   r_win_row, r_win_col;
   logic              w_acc, w_win, w_last, w_out_valid;
   logic [IDX_W-1:0]  w_win_idx, w_ofm_idx;

   assign w_acc     = in_valid && (r_state inside {IDLE, FILL, CONV});
   assign w_win     = (r_row >= KM1) && (r_col >= KM1);
   assign w_last    = (r_row == LAST_R) && (r_col == LAST_C);
   assign w_win_idx = IDX_W'(int'(r_win_row) * OW + int'(r_win_col));

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (w_acc) w_nxt = FILL;
         FILL:    if (w_acc && w_win) w_nxt = CONV;
         CONV:    if (w_acc && w_last) w_nxt = DRAIN;
         // Delay line is in-order, so the last index emerging means nothing is left in flight.
         DRAIN:   if (w_out_valid && (w_ofm_idx == LAST_OFM)) w_nxt = DONE;
         DONE:    w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_pix        <= '0;
         r_win_valid  <= 1'b0;
         r_win_row    <= '0;
         r_win_col    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         r_state      <= w_nxt;
         r_busy       <= (w_nxt != IDLE);
         r_frame_done <= (w_nxt == DONE);
         r_proto_err  <= in_valid && (r_state inside {DRAIN, DONE});
         r_win_valid  <= w_acc && w_win;
         if (w_acc && w_win) begin
            r_win_row <= r_row - KM1;
            r_win_col <= r_col - KM1;
         end
         if (w_acc) begin
            if (w_last) begin
               r_row <= '0;
               r_col <= '0;
               r_pix <= '0;
            end else begin
               r_pix <= r_pix + 1'b1;
               if (r_col == LAST_C) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
         end
      end
   end

   conv_valid_delay #(.LAT(MAC_LAT), .IW(IDX_W)) u_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (r_win_valid),
      .i_idx (w_win_idx),
      .o_vld (w_out_valid),
      .o_idx (w_ofm_idx)
   );

   assign busy       = r_busy;
   assign pix_row    = r_row;
   assign pix_col    = r_col;
   assign wgt_we     = w_acc && (r_pix < NWGT);
   assign wgt_addr   = r_pix[3:0];
   assign lb_we      = w_acc;
   assign win_valid  = r_win_valid;
   assign win_row    = r_win_row;
   assign win_col    = r_win_col;
   assign out_valid  = w_out_valid;
   assign ofm_idx    = w_ofm_idx;
   assign frame_done = r_frame_done;
   assign proto_err  = r_proto_err;
endmodule

// File: doc/conv_frame_sched.md
Name: conv_frame_sched

Overview:
Frame-level controller for the 14x14 IFM / 3x3 weight / 12x12 OFM convolution datapath.
- Counts incoming pixels and generates weight-buffer and line-buffer write strobes.
- Decides when a complete 3x3 window is present and issues it to the MAC datapath with its OFM coordinates.
- Tracks MAC latency to produce the top-level out_valid with the OFM index, then signals end of frame.

Parameters:
IMG_W, 14, IFM columns
IMG_H, 14, IFM rows
K, 3, kernel size (weights = K*K)
MAC_LAT, 2, cycles from win_valid to MAC result valid (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock, asynchronous and active-low
in_valid  in  1  one IFM pixel (and, for pixels 0..K*K-1, one weight) present this cycle
busy  out  1  registered; high whenever state != IDLE
pix_row  out  4  row of the pixel accepted this cycle (comb from counters)
pix_col  out  4  column of the pixel accepted this cycle (comb)
wgt_we  out  1  comb: accept && pix_idx < K*K
wgt_addr  out  4  comb: pix_idx[3:0], weight slot to write
lb_we  out  1  comb: accept; line-buffer write strobe
win_valid  out  1  registered; window at (win_row, win_col) is complete in line buffer
win_row  out  4  registered OFM row of issued window (0..IMG_H-K)
win_col  out  4  registered OFM col of issued window (0..IMG_W-K)
out_valid  out  1  registered; MAC result for ofm_idx valid this cycle
ofm_idx  out  8  registered; win_row*(IMG_W-K+1)+win_col, delayed MAC_LAT
frame_done  out  1  registered one-cycle pulse after last out_valid
proto_err  out  1  registered one-cycle pulse: in_valid high in DRAIN or DONE

Behaviour:
- Reset: all registered outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately; the MAC delay line is cleared, so no stale out_valid.
- accept = in_valid && state in {IDLE, FILL, CONV}. Counters (row, col, pix_idx) advance only on accept; col wraps IMG_W-1 -> 0 with row++.
- States:
  - IDLE: accept -> FILL.
  - FILL: when the accepted pixel has row>=K-1 && col>=K-1 -> CONV.
  - CONV: accepted pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: stays while any window is in flight; when the last out_valid is asserted -> DONE.
  - DONE: one cycle, frame_done=1 -> IDLE.
- Window issue: if the pixel accepted at cycle t has row>=K-1 and col>=K-1, then win_valid=1 at t+1 with win_row=row-(K-1), win_col=col-(K-1). Otherwise win_valid=0 at t+1.
- This gives 12 windows per row, with 2 bubble cycles at cols 0..1; 144 windows per frame.
- Latency: out_valid and ofm_idx are win_valid and the index through a MAC_LAT-deep shift register, so out_valid = win_valid delayed MAC_LAT cycles.
- in_valid gaps: counters and state hold. The delay line keeps shifting, so in-flight results still emerge.
- in_valid in DRAIN/DONE: the pixel is not accepted, no strobes, proto_err=1 next cycle, frame continues normally.
- A new frame may start at earliest the cycle after DONE (IDLE). Weights are rewritten every frame.
- Width rule: ofm_idx is a full 8-bit product/sum; max 143, no wrap.

Decomposition:
- Shared package conv_pkg holds:
  - IMG_W/IMG_H/K defaults and derived OFM_W=IMG_W-K+1, OFM_H, N_PIX=IMG_W*IMG_H, N_WGT=K*K.
  - Width constants: row/col width = $clog2(IMG_W), idx width = $clog2(OFM_W*OFM_H).
  - State enum {IDLE, FILL, CONV, DRAIN, DONE}.
- One sub-module: conv_valid_delay, a MAC_LAT-deep valid+index shift register with async clear.

Test Plan:
- Reset, then a 196-cycle contiguous in_valid burst from cycle 0:
  - wgt_we high in cycles 0..8 with wgt_addr 0..8.
  - first win_valid at cycle 31 (row0, col0); first out_valid at cycle 33 with ofm_idx 0.
  - last out_valid at cycle 198 with ofm_idx 143; frame_done at cycle 199; busy low at 200.
- Same frame: count win_valid pulses = 144. Within row 5 pixels (cycles 70..83), win_valid is low at cycles 71,72 and high at 73..84.
- 5-cycle in_valid gap after pixel 50: all later events shift by +5, with last out_valid at cycle 203. A window already issued before the gap still produces out_valid on time.
- in_valid held 2 extra cycles after pixel 195: proto_err pulses at cycles 197 and 198, no lb_we, ofm_idx sequence unchanged.
- rst_n low at cycle 100 for 1 cycle, then a new 196-pixel frame: outputs 0 during reset, no out_valid from the aborted frame, new frame timing identical to the first scenario.
- Back-to-back frames, second starting at cycle 200: wgt_we 200..208, ofm_idx restarts at 0 at cycle 233.
